// File: rtl/bp_be_issue_queue.sv
// bp_be_issue_queue: speculative in-order issue queue between the FE queue
// and the BE checker. Entries are issued through a speculative read pointer
// and freed only when committed through a separate commit pointer.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   enq_data_i/enq_v_i        FE packet and valid
//   enq_ready_o               space available (not masked by clr_i)
//   issue_data_o/issue_v_o    oldest unissued entry and its valid
//   issue_yumi_i              consumer takes issue_data_o this cycle
//   deq_i                     commit (free) the oldest issued entry
//   roll_i                    rewind the read pointer to the commit pointer
//   clr_i                     discard all entries
//   count_o                   entries held (issued-uncommitted plus unissued)
//   credits_full_o/_empty_o   count_o == els_p / count_o == 0
module bp_be_issue_queue #(
  parameter  int unsigned entry_width_p = 64,
  parameter  int unsigned els_p         = 8,
  localparam int unsigned ptr_width_lp  = $clog2(els_p) + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [entry_width_p-1:0] enq_data_i,
  input  logic                     enq_v_i,
  output logic                     enq_ready_o,
  output logic [entry_width_p-1:0] issue_data_o,
  output logic                     issue_v_o,
  input  logic                     issue_yumi_i,
  input  logic                     deq_i,
  input  logic                     roll_i,
  input  logic                     clr_i,
  output logic [ptr_width_lp-1:0]  count_o,
  output logic                     credits_full_o,
  output logic                     credits_empty_o
);

  localparam int unsigned idx_width_lp = $clog2(els_p);
  localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);
  localparam logic [ptr_width_lp-1:0] ptr_els_lp = ptr_width_lp'(els_p);

  logic [entry_width_p-1:0] r_mem [els_p];
  logic [ptr_width_lp-1:0]  r_wptr, r_rptr, r_cptr;
  logic [ptr_width_lp-1:0]  w_wptr_n, w_rptr_n, w_cptr_n;
  logic                     w_enq, w_yumi, w_deq;

  // Occupancy and status decode, all from registered pointers only.
  assign count_o         = r_wptr - r_cptr;
  assign enq_ready_o     = (count_o != ptr_els_lp);
  assign credits_full_o  = (count_o == ptr_els_lp);
  assign credits_empty_o = (count_o == '0);
  assign issue_v_o       = (r_rptr != r_wptr);
  assign issue_data_o    = r_mem[r_rptr[idx_width_lp-1:0]];

  // Illegal yumi/deq are masked so a protocol error cannot corrupt pointers.
  assign w_enq  = enq_v_i & enq_ready_o;
  assign w_yumi = issue_yumi_i & issue_v_o;
  assign w_deq  = deq_i & (r_cptr != r_rptr);

  // Next pointers: clear > roll > independent enq/yumi/deq.
  always_comb begin
    w_wptr_n = r_wptr;
    w_rptr_n = r_rptr;
    w_cptr_n = r_cptr;
    if (clr_i) begin
      w_wptr_n = '0;
      w_rptr_n = '0;
      w_cptr_n = '0;
    end else begin
      if (w_enq) w_wptr_n = r_wptr + ptr_one_lp;
      if (w_deq) w_cptr_n = r_cptr + ptr_one_lp;
      // Roll targets the post-deq commit pointer; a same-cycle yumi is dropped.
      if (roll_i)      w_rptr_n = w_cptr_n;
      else if (w_yumi) w_rptr_n = r_rptr + ptr_one_lp;
    end
  end

  // Pointer state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cptr <= '0;
    end else begin
      r_wptr <= w_wptr_n;
      r_rptr <= w_rptr_n;
      r_cptr <= w_cptr_n;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (w_enq && !clr_i) begin
      r_mem[r_wptr[idx_width_lp-1:0]] <= enq_data_i;
    end
  end

  // Protocol checks.
  a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(deq_i && (r_cptr == r_rptr)))
    else $error("bp_be_issue_queue: deq_i with no issued entry");

  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(issue_yumi_i && !issue_v_o))
    else $error("bp_be_issue_queue: issue_yumi_i without issue_v_o");

endmodule
